// File: rtl/mem_bus_master.sv
// Single-access bus master for a 16x8 memory. Accepts read and write requests from the core
// and drives the memory strobes and the shared tristate data bus, then returns a response pulse.
module mem_bus_master #(
   parameter int ADDR_W = 4,
   parameter int DATA_W = 8,
   parameter int RD_LAT = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic [ADDR_W-1:0] addr,
   output logic              re,
   output logic              we,
   inout  wire  [DATA_W-1:0] data_bus
);

   localparam int               CNT_W    = 4;
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(RD_LAT - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      READ  = 2'd2,
      TURN  = 2'd3
   } state_t;

   state_t            state;
   state_t            state_n;
   logic [CNT_W-1:0]  cnt;
   logic [CNT_W-1:0]  cnt_n;
   logic [ADDR_W-1:0] addr_n;
   logic              re_n;
   logic              we_n;
   logic              drive_en;
   logic              drive_en_n;
   logic              rsp_valid_n;
   logic [DATA_W-1:0] wdata_q;
   logic [DATA_W-1:0] wdata_n;
   logic [DATA_W-1:0] rdata_n;

   // Handshake: a request transfers on a rising edge where req_valid && req_ready are both high;
   // the core holds req_* stable until then, and req_ready is never high outside IDLE or in reset.
   assign req_ready = (state == IDLE) && !rst;

   // Only the master's write cycle drives the bus; every other cycle leaves it to the memory.
   assign data_bus = drive_en ? wdata_q : {DATA_W{1'bz}};

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         addr      <= '0;
         re        <= 1'b0;
         we        <= 1'b0;
         drive_en  <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         wdata_q   <= '0;
      end else begin
         state     <= state_n;
         cnt       <= cnt_n;
         addr      <= addr_n;
         re        <= re_n;
         we        <= we_n;
         drive_en  <= drive_en_n;
         rsp_valid <= rsp_valid_n;
         rsp_rdata <= rdata_n;
         wdata_q   <= wdata_n;
      end
   end

   // Next values of every registered output, so nothing reaches the pins combinationally from req_*.
   always_comb begin
      state_n     = state;
      cnt_n       = cnt;
      addr_n      = addr;
      re_n        = 1'b0;
      we_n        = 1'b0;
      drive_en_n  = 1'b0;
      rsp_valid_n = 1'b0;
      wdata_n     = wdata_q;
      rdata_n     = rsp_rdata;
      case (state)
         IDLE: begin
            if (req_valid && req_ready) begin
               addr_n  = req_addr;
               wdata_n = req_wdata;
               if (req_we) begin
                  state_n    = WRITE;
                  we_n       = 1'b1;
                  drive_en_n = 1'b1;
               end else begin
                  state_n = READ;
                  re_n    = 1'b1;
                  cnt_n   = CNT_INIT;
               end
            end
         end
         WRITE: begin
            state_n     = TURN;
            rsp_valid_n = 1'b1;
         end
         READ: begin
            if (cnt == '0) begin
               rdata_n     = data_bus;
               state_n     = TURN;
               rsp_valid_n = 1'b1;
            end else begin
               cnt_n = cnt - 1'b1;
               re_n  = 1'b1;
            end
         end
         TURN: begin
            state_n = IDLE;
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

   a_strobe_excl : assert property (@(posedge clk) disable iff (rst) !(re && we));
   a_no_drive_re : assert property (@(posedge clk) disable iff (rst) re |-> !drive_en);
   a_turnaround  : assert property (@(posedge clk) disable iff (rst) $past(re) |-> !drive_en);

endmodule

// File: tb/tb_mem_bus_master.sv
// Bench for mem_bus_master: memory model plus bus keeper on the shared bus, a vector table,
// hand sequences for the multi-cycle corners, and randomized traffic checked against a reference model.
module tb_mem_bus_master;

   localparam int         ADDR_W = 4;
   localparam int         DATA_W = 8;
   localparam int         RD_LAT = 1;
   localparam logic [7:0] KEEP   = 8'hA5;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic              req_valid, req_ready, req_we, rsp_valid, re, we;
   logic [ADDR_W-1:0] req_addr, addr;
   logic [DATA_W-1:0] req_wdata, rsp_rdata;
   wire  [DATA_W-1:0] data_bus;

   logic              req3_valid, req3_ready, req3_we, rsp3_valid, re3, we3;
   logic [ADDR_W-1:0] req3_addr, addr3;
   logic [DATA_W-1:0] req3_wdata, rsp3_rdata;
   wire  [DATA_W-1:0] data_bus3;

   mem_bus_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) u_dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
      .addr(addr), .re(re), .we(we), .data_bus(data_bus)
   );

   mem_bus_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(3)) u_dut3 (
      .clk(clk), .rst(rst),
      .req_valid(req3_valid), .req_ready(req3_ready), .req_we(req3_we),
      .req_addr(req3_addr), .req_wdata(req3_wdata),
      .rsp_valid(rsp3_valid), .rsp_rdata(rsp3_rdata),
      .addr(addr3), .re(re3), .we(we3), .data_bus(data_bus3)
   );

   // Memories on each bus; the keeper drives a known pattern whenever nobody should own the bus.
   logic       mem_clr;
   logic [7:0] mem  [16];
   logic [7:0] mem3 [16];
   wire  [7:0] mem_rd  = mem[addr];
   wire  [7:0] mem3_rd = mem3[addr3];

   assign data_bus  = re ? mem_rd : 8'hzz;
   assign data_bus  = (!re && !we) ? KEEP : 8'hzz;
   assign data_bus3 = re3 ? mem3_rd : 8'hzz;

   always @(posedge clk) begin
      if (mem_clr) begin
         for (int i = 0; i < 16; i++) begin
            mem[i]  <= 8'h00;
            mem3[i] <= 8'(i * 17);
         end
      end else begin
         if (we)  mem[addr]   <= data_bus;
         if (we3) mem3[addr3] <= data_bus3;
      end
   end

   int errors = 0;
   int checks = 0;
   bit mon_en = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference model: array of memory contents and the last value returned by a read.
   logic [7:0] ref_mem [16];
   logic [7:0] last_rd;
   logic [7:0] exp_q[$];

   function automatic logic [7:0] model_apply(input logic w, input logic [3:0] a, input logic [7:0] d);
      if (w) ref_mem[a] = d;
      else   last_rd    = ref_mem[a];
      return last_rd;
   endfunction

   always @(negedge clk) begin
      if (mon_en) begin
         chk("strobe_excl", {31'd0, re && we}, 32'd0);
         if (re)       chk("bus_read", {24'd0, data_bus}, {24'd0, mem[addr]});
         else if (!we) chk("bus_release", {24'd0, data_bus}, {24'd0, KEEP});
      end
   end

   // Issue one request, wait for its response and check strobes, latency and returned data.
   task automatic do_req(input logic w, input logic [3:0] a, input logic [7:0] d,
                         input logic [7:0] exp_rd, input int exp_lat, input string name);
      int  n;
      int  lat;
      int  re_cnt;
      bit  got;
      exp_q.push_back(exp_rd);
      req_we = w; req_addr = a; req_wdata = d; req_valid = 1'b1;
      n = 0;
      @(negedge clk);
      while (!req_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!req_ready) begin
         chk({name, "_accept"}, 32'd0, 32'd1);
         req_valid = 1'b0;
         void'(exp_q.pop_front());
         return;
      end
      @(posedge clk);
      #1 req_valid = 1'b0;
      lat = 0; re_cnt = 0; got = 1'b0;
      for (int c = 1; c <= 20 && !got; c++) begin
         @(negedge clk);
         if (c == 1) begin
            chk({name, "_addr"}, {28'd0, addr}, {28'd0, a});
            if (w) begin
               chk({name, "_we"}, {31'd0, we}, 32'd1);
               chk({name, "_wbus"}, {24'd0, data_bus}, {24'd0, d});
            end else begin
               chk({name, "_re"}, {31'd0, re}, 32'd1);
            end
         end
         if (re) re_cnt++;
         if (rsp_valid) begin
            got = 1'b1;
            lat = c;
         end
      end
      chk({name, "_lat"}, lat, exp_lat);
      chk({name, "_rdata"}, {24'd0, rsp_rdata}, {24'd0, exp_q.pop_front()});
      chk({name, "_re_cycles"}, re_cnt, w ? 0 : RD_LAT);
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic       w;
      logic [3:0] a;
      logic [7:0] d;
      logic [7:0] exp_rd;
      int         exp_lat;
   } vec_t;

   vec_t vecs [7];

   initial begin
      #300000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic       w;
      logic [3:0] a;
      logic [7:0] d;
      logic [7:0] e;

      vecs[0] = '{1'b1, 4'd2,  8'hB5, 8'h00, 2};
      vecs[1] = '{1'b0, 4'd8,  8'h00, 8'h00, 2};
      vecs[2] = '{1'b0, 4'd2,  8'h00, 8'hB5, 2};
      vecs[3] = '{1'b1, 4'd0,  8'h71, 8'hB5, 2};
      vecs[4] = '{1'b0, 4'd0,  8'h00, 8'h71, 2};
      vecs[5] = '{1'b1, 4'd15, 8'hFF, 8'h71, 2};
      vecs[6] = '{1'b0, 4'd15, 8'h00, 8'hFF, 2};
      for (int i = 0; i < 16; i++) ref_mem[i] = 8'h00;
      last_rd = 8'h00;

      rst = 1'b1; mem_clr = 1'b1;
      req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
      req3_valid = 1'b0; req3_we = 1'b0; req3_addr = '0; req3_wdata = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_re", {31'd0, re}, 32'd0);
      chk("rst_we", {31'd0, we}, 32'd0);
      chk("rst_addr", {28'd0, addr}, 32'd0);
      chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      chk("rst_rdata", {24'd0, rsp_rdata}, 32'd0);
      chk("rst_ready", {31'd0, req_ready}, 32'd0);
      chk("rst_bus", {24'd0, data_bus}, {24'd0, KEEP});
      @(posedge clk);
      #1 rst = 1'b0; mem_clr = 1'b0; mon_en = 1'b1;
      @(negedge clk);
      chk("ready_after_rst", {31'd0, req_ready}, 32'd1);
      @(posedge clk);
      #1;

      for (int i = 0; i < 7; i++) begin
         void'(model_apply(vecs[i].w, vecs[i].a, vecs[i].d));
         do_req(vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].exp_rd, vecs[i].exp_lat,
                $sformatf("vec%0d", i));
      end
      chk("mem2_holds", {24'd0, mem[2]}, 32'hB5);

      // Back-to-back with req_valid held: the read waits out WRITE and TURN.
      req_valid = 1'b1; req_we = 1'b1; req_addr = 4'd15; req_wdata = 8'h3C;
      @(negedge clk);
      chk("b2b_ready_idle", {31'd0, req_ready}, 32'd1);
      @(posedge clk);
      #1 req_we = 1'b0;
      @(negedge clk);
      chk("b2b_ready_write", {31'd0, req_ready}, 32'd0);
      chk("b2b_wbus", {24'd0, data_bus}, 32'h3C);
      chk("b2b_waddr", {28'd0, addr}, 32'd15);
      @(negedge clk);
      chk("b2b_ready_turn", {31'd0, req_ready}, 32'd0);
      chk("b2b_wrsp", {31'd0, rsp_valid}, 32'd1);
      @(negedge clk);
      chk("b2b_ready_again", {31'd0, req_ready}, 32'd1);
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      chk("b2b_re", {31'd0, re}, 32'd1);
      chk("b2b_raddr", {28'd0, addr}, 32'd15);
      @(negedge clk);
      chk("b2b_rrsp", {31'd0, rsp_valid}, 32'd1);
      chk("b2b_rdata", {24'd0, rsp_rdata}, 32'h3C);
      void'(model_apply(1'b1, 4'd15, 8'h3C));
      void'(model_apply(1'b0, 4'd15, 8'h00));
      @(posedge clk);
      #1;

      for (int i = 0; i < 40; i++) begin
         w = 1'($urandom_range(0, 1));
         a = 4'($urandom_range(0, 15));
         d = 8'($urandom_range(0, 255));
         e = model_apply(w, a, d);
         do_req(w, a, d, e, w ? 2 : RD_LAT + 1, $sformatf("rnd%0d", i));
      end

      // Read with RD_LAT=3 on the second instance; its memory holds 0x22 at address 2.
      req3_valid = 1'b1; req3_we = 1'b0; req3_addr = 4'd2;
      @(negedge clk);
      chk("lat3_ready", {31'd0, req3_ready}, 32'd1);
      @(posedge clk);
      #1 req3_valid = 1'b0;
      for (int c = 1; c <= 4; c++) begin
         @(negedge clk);
         chk($sformatf("lat3_re_c%0d", c), {31'd0, re3}, (c <= 3) ? 32'd1 : 32'd0);
         chk($sformatf("lat3_rsp_c%0d", c), {31'd0, rsp3_valid}, (c == 4) ? 32'd1 : 32'd0);
      end
      chk("lat3_rdata", {24'd0, rsp3_rdata}, 32'h22);
      @(posedge clk);
      #1;

      // Reset lands on the edge that would end the READ cycle: access dropped, no response.
      req_valid = 1'b1; req_we = 1'b0; req_addr = 4'd2;
      @(negedge clk);
      chk("abort_ready", {31'd0, req_ready}, 32'd1);
      @(posedge clk);
      #1 req_valid = 1'b0; rst = 1'b1;
      @(negedge clk);
      chk("abort_in_read", {31'd0, re}, 32'd1);
      @(posedge clk);
      #1 rst = 1'b0;
      last_rd = 8'h00;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk($sformatf("abort_no_rsp%0d", c), {31'd0, rsp_valid}, 32'd0);
         chk($sformatf("abort_re%0d", c), {31'd0, re}, 32'd0);
         chk($sformatf("abort_ready%0d", c), {31'd0, req_ready}, 32'd1);
      end
      chk("abort_rdata", {24'd0, rsp_rdata}, 32'h00);
      @(posedge clk);
      #1;
      e = model_apply(1'b0, 4'd15, 8'h00);
      do_req(1'b0, 4'd15, 8'h00, e, RD_LAT + 1, "post_abort");

      mon_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
